// File: rtl/line_matrix_seq.sv
// Hardware sequencer for the GPO line matrix: holds a shadow routing table and
// replays it onto the matrix clk/rstn/select pins on commit.
module line_matrix_seq #(
  parameter int NUM_IN    = 8,
  parameter int NUM_OUT   = 9,
  parameter int SEL_W     = 4,
  parameter int RST_CYC   = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_out_sel,
  input  logic [SEL_W-1:0] cfg_in_sel,
  input  logic             cfg_enable,
  input  logic             clear,
  input  logic             commit,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             lm_clk,
  output logic             lm_rstn,
  output logic [SEL_W-1:0] lm_input_select,
  output logic [SEL_W-1:0] lm_output_select
);

  localparam int CNT_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

  logic [2:0]       state, state_n;
  logic [SEL_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             skip, skip_n;
  logic             pending;
  logic             started;

  logic [NUM_OUT-1:0] tbl_en;
  logic [SEL_W-1:0]   tbl_sel [NUM_OUT];

  logic             adv;
  logic             load;
  logic             show;
  logic             wr_acc;
  logic             wr_bad;
  logic [SEL_W-1:0] osel_n;
  logic [SEL_W-1:0] isel_n;

  assign busy      = (state != S_IDLE);
  assign cfg_ready = started & (state == S_IDLE) & ~commit;
  assign wr_acc    = cfg_valid & cfg_ready;
  assign wr_bad    = ({1'b0, cfg_out_sel} >= (SEL_W+1)'(NUM_OUT)) ||
                     ({1'b0, cfg_in_sel}  >= (SEL_W+1)'(NUM_IN));

  // Shadow table; clear is applied before a same-cycle write so the write survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_en  <= '0;
      cfg_err <= 1'b0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        tbl_sel[i] <= '0;
      end
    end else begin
      cfg_err <= wr_acc & wr_bad;
      if (clear && (state == S_IDLE)) begin
        tbl_en <= '0;
      end
      if (wr_acc && !wr_bad) begin
        tbl_en[cfg_out_sel]  <= cfg_enable;
        tbl_sel[cfg_out_sel] <= cfg_in_sel;
      end
    end
  end

  // Entry evaluation (load) is shared by the end of RESET and every advance,
  // so a disabled entry costs exactly one SETUP cycle with skip set.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    skip_n  = skip;
    adv     = 1'b0;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (commit || pending) begin
          state_n = S_RESET;
          cnt_n   = CNT_W'(RST_CYC - 1);
        end
      end
      S_RESET: begin
        if (cnt == '0) begin
          idx_n = '0;
          load  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_SETUP: begin
        if (skip) begin
          adv = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_PULSE;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          state_n = S_HOLD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        adv = 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (adv) begin
      if (idx == LAST_IDX) begin
        state_n = S_DONE;
      end else begin
        idx_n = idx + SEL_W'(1);
        load  = 1'b1;
      end
    end

    if (load) begin
      state_n = S_SETUP;
      skip_n  = ~tbl_en[idx_n];
      cnt_n   = CNT_W'(SETUP_CYC - 1);
    end
  end

  always_comb begin
    show   = ((state_n == S_SETUP) && !skip_n) ||
             (state_n == S_PULSE) || (state_n == S_HOLD);
    osel_n = '0;
    isel_n = '0;
    if (show) begin
      osel_n = idx_n;
      isel_n = tbl_sel[idx_n];
    end
  end

  // Pin outputs are registered from the next-state decode so they are glitch-free
  // and line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= '0;
      cnt              <= '0;
      skip             <= 1'b0;
      pending          <= 1'b0;
      started          <= 1'b0;
      done             <= 1'b0;
      lm_clk           <= 1'b0;
      lm_rstn          <= 1'b0;
      lm_input_select  <= '0;
      lm_output_select <= '0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      cnt              <= cnt_n;
      skip             <= skip_n;
      started          <= 1'b1;
      done             <= (state_n == S_DONE);
      lm_clk           <= (state_n == S_PULSE);
      lm_rstn          <= (state_n != S_RESET);
      lm_input_select  <= isel_n;
      lm_output_select <= osel_n;
      if (state == S_IDLE) begin
        if (state_n == S_RESET) begin
          pending <= 1'b0;
        end
      end else if (commit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
